instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Fetch stage of the 24-bit pipeline. It holds the PC and issues one-outstanding-request reads to instruction memory over a req/ack handshake with variable latency. It delivers {valid, pc, inst} into the IF/ID pipeline register, which the decode stage consumes. Branch redirects from execute flush the register and steer the PC.

Parameters:
PC_WIDTH, 24, width of PC and memory address
INST_WIDTH, 32, instruction width
RESET_PC, 24'h000000, PC value loaded on reset
PC_STEP, 1, PC increment per instruction (word-addressed memory)
NOP_INST, 32'h00000000, instruction placed in the register on a bubble or flush

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  IF/ID advance enable from the hazard unit; 1 = register may load
branchTaken  in  1  redirect request from execute
branchTarget  in  24  redirect PC, valid when branchTaken=1
imemReq  out  1  memory request, held until imemAck
imemAddr  out  24  request address, stable while imemReq=1
imemAck  in  1  memory response strobe, 1 cycle, data valid same cycle
imemData  in  32  instruction word, valid when imemAck=1
bufferOut  out  57  IF/ID register: [56]=valid, [55:32]=pc, [31:0]=inst

Behaviour:
- Reset (async, any time including mid-request):
  - state=REQ, pc=RESET_PC, hold register cleared.
  - bufferOut={0, 24'h0, NOP_INST}; imemReq=0 while rst=1.
  - Any in-flight memory response is abandoned. Memory is reset by the same rst.
- FSM states: REQ, HOLD, DISCARD. Outputs are decoded from state and registers:
  - imemReq=1 in REQ and DISCARD, 0 in HOLD.
  - imemAddr=pc in REQ, discardAddr in DISCARD.
- Address stability: once imemReq=1, imemAddr must not change until the cycle imemAck=1. Back-to-back requests are allowed; the next address is presented the cycle after ack.
- REQ, evaluated in priority order:
  - branchTaken=1 and imemAck=1: drop imemData, pc<=branchTarget, stay REQ.
  - branchTaken=1 and imemAck=0: discardAddr<=pc, pc<=branchTarget, go to DISCARD.
  - imemAck=1 and en=1: bufferOut<={1, pc, imemData}, pc<=pc+PC_STEP, stay REQ.
  - imemAck=1 and en=0: hold<={pc, imemData}, pc<=pc+PC_STEP, go to HOLD. bufferOut unchanged.
  - imemAck=0 and en=1: bufferOut<=bubble {0, pc, NOP_INST}.
  - imemAck=0 and en=0: nothing changes.
- HOLD:
  - branchTaken=1: discard hold, pc<=branchTarget, go to REQ.
  - en=1: bufferOut<={1, hold}, go to REQ.
  - otherwise remain in HOLD.
- DISCARD:
  - Wait for imemAck, then drop the data and go to REQ. The next request goes to pc, which holds the target.
  - branchTaken again in DISCARD: pc<=new target, discardAddr unchanged. The latest branch wins.
- Flush rule: branchTaken=1 loads bufferOut with bubble {0, 24'h0, NOP_INST} regardless of en. Flush has priority over stall.
- Latency: with a 1-cycle memory and en=1, throughput is 1 instruction every 2 cycles (request cycle + ack cycle). The instruction appears in bufferOut on the edge where ack is sampled.
- PC arithmetic is modulo 2^24; pc+PC_STEP wraps silently from 24'hFFFFFF to 24'h000000.
- valid=0 entries must be treated as NOP by decode. The pc field of a bubble is don't-care, except that the flush bubble's pc is 0.

Test Plan:
- Reset release, memory acks every request after 1 cycle with data=addr+32'hA0000000, en=1 -> bufferOut shows valid entries pc=0,1,2,... with inst 32'hA0000000, A0000001, ...; imemAddr stable while imemReq=1.
- Ack latency 3 cycles, en=1 -> 2 bubble cycles (valid=0, inst=NOP) between valid entries; imemAddr constant through the wait.
- en=0 on the ack cycle for pc=5, held low 4 cycles -> imemReq=0 during HOLD, bufferOut unchanged; on en=1, bufferOut={1, 5, inst5} and the next request is addr 6.
- branchTaken (target 24'h000100) while a request to addr 7 is pending -> bufferOut flushed to {0, 0, NOP}; addr 7 still held until ack and its data dropped; next request addr 24'h000100.
- branchTaken on the same cycle as ack for addr 9 -> data 9 never valid in bufferOut; next request addr is the target. Branch with en=0 also flushes bufferOut.
- pc=24'hFFFFFF fetched -> next imemAddr=24'h000000. Async rst asserted mid-request -> outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and fills the IF/ID register, honouring stalls and branch flushes.
module instruction_fetch_stage #(
  parameter int                     PC_WIDTH   = 24,
  parameter int                     INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = 24'h000000,
  parameter int                     PC_STEP    = 1,
  parameter logic [INST_WIDTH-1:0]  NOP_INST   = 32'h00000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           branchTaken,
  input  logic [PC_WIDTH-1:0]            branchTarget,
  output logic                           imemReq,
  output logic [PC_WIDTH-1:0]            imemAddr,
  input  logic                           imemAck,
  input  logic [INST_WIDTH-1:0]          imemData,
  output logic [PC_WIDTH+INST_WIDTH:0]   bufferOut
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_e;

  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH+INST_WIDTH:0] FLUSH_ENTRY = {1'b0, {PC_WIDTH{1'b0}}, NOP_INST};

  fetchState_e                     stateR, stateS;
  logic [PC_WIDTH-1:0]             pcR, pcS;
  logic [PC_WIDTH-1:0]             discardAddrR, discardAddrS;
  logic [PC_WIDTH+INST_WIDTH-1:0]  holdR, holdS;
  logic [PC_WIDTH+INST_WIDTH:0]    bufferR, bufferS;

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR       <= REQ;
      pcR          <= RESET_PC;
      discardAddrR <= {PC_WIDTH{1'b0}};
      holdR        <= {(PC_WIDTH+INST_WIDTH){1'b0}};
      bufferR      <= FLUSH_ENTRY;
    end else begin
      stateR       <= stateS;
      pcR          <= pcS;
      discardAddrR <= discardAddrS;
      holdR        <= holdS;
      bufferR      <= bufferS;
    end
  end

  // Next-state logic; a branch always flushes the IF/ID register, even while stalled.
  always_comb begin
    stateS       = stateR;
    pcS          = pcR;
    discardAddrS = discardAddrR;
    holdS        = holdR;
    bufferS      = bufferR;
    case (stateR)
      REQ: begin
        if (branchTaken) begin
          bufferS = FLUSH_ENTRY;
          pcS     = branchTarget;
          if (imemAck) begin
            stateS = REQ;
          end else begin
            discardAddrS = pcR;
            stateS       = DISCARD;
          end
        end else if (imemAck) begin
          pcS = pcR + PC_INC;
          if (en) begin
            bufferS = {1'b1, pcR, imemData};
          end else begin
            holdS  = {pcR, imemData};
            stateS = HOLD;
          end
        end else if (en) begin
          bufferS = {1'b0, pcR, NOP_INST};
        end else begin
          bufferS = bufferR;
        end
      end
      HOLD: begin
        if (branchTaken) begin
          bufferS = FLUSH_ENTRY;
          pcS     = branchTarget;
          stateS  = REQ;
        end else if (en) begin
          bufferS = {1'b1, holdR};
          stateS  = REQ;
        end else begin
          stateS = HOLD;
        end
      end
      DISCARD: begin
        // The abandoned request keeps its address until memory answers it.
        if (branchTaken) begin
          bufferS = FLUSH_ENTRY;
          pcS     = branchTarget;
        end else begin
          bufferS = bufferR;
        end
        if (imemAck) begin
          stateS = REQ;
        end else begin
          stateS = DISCARD;
        end
      end
      default: begin
        stateS = REQ;
      end
    endcase
  end

  // Memory request outputs decoded from the state register.
  always_comb begin
    imemReq  = 1'b0;
    imemAddr = pcR;
    if (rst) begin
      imemReq = 1'b0;
    end else begin
      imemReq = (stateR != HOLD);
    end
    if (stateR == DISCARD) begin
      imemAddr = discardAddrR;
    end else begin
      imemAddr = pcR;
    end
  end

  assign bufferOut = bufferR;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: bench-side memory responder, fetch-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        branchTaken = 1'b0;
  logic [23:0] branchTarget = 24'h000000;
  logic        imemReq;
  logic [23:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h00000000;
  logic [56:0] bufferOut;

  localparam logic [56:0] FLUSH_ENTRY = {1'b0, 24'h000000, 32'h00000000};

  instruction_fetch_stage dut (
    .clk(clk), .rst(rst), .en(en), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fetch-level model: next PC, a parked fetched word, an abandoned request, the IF/ID entry.
  logic [23:0] mPc;
  bit          mHoldV;
  logic [23:0] mHoldPc;
  logic [31:0] mHoldInst;
  bit          mDisc;
  logic [23:0] mDiscAddr;
  bit          mBufV;
  bit          mPcKnown;
  logic [23:0] mBufPc;
  logic [31:0] mBufInst;

  // Memory responder: ack comes memLat cycles after the request first appears.
  int          memLat = 1;
  int          memWait = 0;
  bit          memBusy = 1'b0;
  bit          memStarted = 1'b0;
  logic [23:0] memAddr = 24'h000000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 24'h000000; mHoldV = 1'b0; mDisc = 1'b0; mDiscAddr = 24'h000000;
    mBufV = 1'b0; mPcKnown = 1'b1; mBufPc = 24'h000000; mBufInst = 32'h00000000;
  endtask

  task automatic modelFlush();
    mBufV = 1'b0; mPcKnown = 1'b1; mBufPc = 24'h000000; mBufInst = 32'h00000000;
  endtask

  task automatic modelStep();
    if (mHoldV) begin
      if (branchTaken) begin
        mHoldV = 1'b0; mPc = branchTarget; modelFlush();
      end else if (en) begin
        mHoldV = 1'b0; mBufV = 1'b1; mPcKnown = 1'b1; mBufPc = mHoldPc; mBufInst = mHoldInst;
      end
    end else if (mDisc) begin
      if (branchTaken) begin
        mPc = branchTarget; modelFlush();
      end
      if (imemAck) mDisc = 1'b0;
    end else begin
      if (branchTaken) begin
        modelFlush();
        if (!imemAck) begin
          mDisc = 1'b1; mDiscAddr = mPc;
        end
        mPc = branchTarget;
      end else if (imemAck) begin
        if (en) begin
          mBufV = 1'b1; mPcKnown = 1'b1; mBufPc = mPc; mBufInst = imemData;
        end else begin
          mHoldV = 1'b1; mHoldPc = mPc; mHoldInst = imemData;
        end
        mPc = mPc + 24'd1;
      end else if (en) begin
        mBufV = 1'b0; mPcKnown = 1'b0; mBufInst = 32'h00000000;
      end
    end
  endtask

  // Compare the DUT against the model at the falling edge, then decide the memory response.
  task automatic prep();
    @(negedge clk);
    check("imemReq", 64'(imemReq), 64'(!mHoldV));
    if (!mHoldV) check("imemAddr", 64'(imemAddr), 64'(mDisc ? mDiscAddr : mPc));
    check("valid", 64'(bufferOut[56]), 64'(mBufV));
    check("inst", 64'(bufferOut[31:0]), 64'(mBufInst));
    if (mBufV || mPcKnown) check("bufPc", 64'(bufferOut[55:32]), 64'(mBufPc));
    memStarted = 1'b0;
    imemAck = 1'b0;
    imemData = 32'h00000000;
    if (memBusy) begin
      check("addrStable", 64'({imemReq, imemAddr}), 64'({1'b1, memAddr}));
      if (memWait == 0) begin
        imemAck = 1'b1;
        imemData = 32'(memAddr) + 32'hA0000000;
        memBusy = 1'b0;
      end else begin
        memWait--;
      end
    end else if (imemReq) begin
      memBusy = 1'b1; memStarted = 1'b1; memAddr = imemAddr; memWait = memLat - 1;
    end
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  // Step until memory acks (or, with startOnly, first sees) a request to addr; caller commits.
  task automatic advanceTo(input logic [23:0] addr, input bit startOnly);
    for (int n = 0; n < 24; n++) begin
      prep();
      if (startOnly ? (memStarted && memAddr == addr) : (imemAck && memAddr == addr)) return;
      commit();
    end
    checks++;
    failures++;
    $display("FAIL advanceTo: no request to %h within 24 cycles", addr);
    prep();
  endtask

  initial begin
    modelReset();
    #2;
    check("rstBuffer", 64'(bufferOut), 64'(FLUSH_ENTRY));
    check("rstReq", 64'(imemReq), 64'(1'b0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Back-to-back fetch with a one-cycle memory.
    advanceTo(24'h000000, 1'b0); commit();
    check("firstFetch", 64'(bufferOut), 64'({1'b1, 24'h000000, 32'hA0000000}));
    advanceTo(24'h000003, 1'b0); commit();
    check("fetch3", 64'(bufferOut), 64'({1'b1, 24'h000003, 32'hA0000003}));

    // Slower memory: ack on the third cycle of the request gives two bubbles.
    memLat = 2;
    prep(); commit();
    check("bubble1", 64'({bufferOut[56], bufferOut[31:0]}), 64'h0);
    prep();
    check("waitAddr", 64'(imemAddr), 64'(24'h000004));
    commit();
    check("bubble2", 64'({bufferOut[56], bufferOut[31:0]}), 64'h0);
    prep(); commit();
    check("slowFetch", 64'(bufferOut), 64'({1'b1, 24'h000004, 32'hA0000004}));

    // Stall on the ack of pc=5 for four cycles.
    memLat = 1;
    advanceTo(24'h000005, 1'b0); en = 1'b0; commit();
    check("holdReq", 64'(imemReq), 64'(1'b0));
    repeat (3) begin prep(); commit(); end
    check("holdBuffer", 64'(bufferOut[56]), 64'(1'b0));
    prep(); en = 1'b1; commit();
    check("releaseBuf", 64'(bufferOut), 64'({1'b1, 24'h000005, 32'hA0000005}));
    check("releaseAddr", 64'({imemReq, imemAddr}), 64'({1'b1, 24'h000006}));

    // Branch while the request to 7 is outstanding.
    memLat = 3;
    advanceTo(24'h000007, 1'b1);
    branchTaken = 1'b1; branchTarget = 24'h000100; commit(); branchTaken = 1'b0;
    check("flushPending", 64'(bufferOut), 64'(FLUSH_ENTRY));
    check("discardAddr", 64'({imemReq, imemAddr}), 64'({1'b1, 24'h000007}));
    advanceTo(24'h000007, 1'b0); commit();
    check("targetAddr", 64'(imemAddr), 64'(24'h000100));
    check("dropped7", 64'(bufferOut[56]), 64'(1'b0));
    memLat = 1;
    advanceTo(24'h000100, 1'b0); commit();
    check("targetFetch", 64'(bufferOut), 64'({1'b1, 24'h000100, 32'hA0000100}));

    // Branch on the ack cycle; then branch on the ack of 9 with en=0.
    advanceTo(24'h000101, 1'b0);
    branchTaken = 1'b1; branchTarget = 24'h000009; commit(); branchTaken = 1'b0;
    check("ackBranchAddr", 64'(imemAddr), 64'(24'h000009));
    advanceTo(24'h000009, 1'b0);
    branchTaken = 1'b1; branchTarget = 24'hFFFFFE; en = 1'b0; commit();
    branchTaken = 1'b0; en = 1'b1;
    check("stallFlush", 64'(bufferOut), 64'(FLUSH_ENTRY));
    check("ackBranch2", 64'({imemReq, imemAddr}), 64'({1'b1, 24'hFFFFFE}));

    // PC wrap.
    advanceTo(24'hFFFFFF, 1'b0); commit();
    check("wrapFetch", 64'(bufferOut), 64'({1'b1, 24'hFFFFFF, 32'hA0FFFFFF}));
    check("wrapAddr", 64'(imemAddr), 64'(24'h000000));

    // Branch out of HOLD, then a second branch while discarding.
    advanceTo(24'h000000, 1'b0); en = 1'b0; commit();
    prep(); branchTaken = 1'b1; branchTarget = 24'h000040; commit();
    branchTaken = 1'b0; en = 1'b1;
    check("holdFlush", 64'(bufferOut), 64'(FLUSH_ENTRY));
    check("holdBranchAddr", 64'({imemReq, imemAddr}), 64'({1'b1, 24'h000040}));
    memLat = 3;
    advanceTo(24'h000040, 1'b1);
    branchTaken = 1'b1; branchTarget = 24'h000080; commit();
    prep(); branchTarget = 24'h0000C0; commit(); branchTaken = 1'b0;
    check("discardKept", 64'(imemAddr), 64'(24'h000040));
    advanceTo(24'h000040, 1'b0); commit();
    check("latestBranch", 64'(imemAddr), 64'(24'h0000C0));

    // Asynchronous reset in the middle of a request.
    advanceTo(24'h0000C0, 1'b1); commit();
    #2 rst = 1'b1;
    imemAck = 1'b0; memBusy = 1'b0; modelReset();
    #1;
    check("asyncRstBuf", 64'(bufferOut), 64'(FLUSH_ENTRY));
    check("asyncRstReq", 64'(imemReq), 64'(1'b0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    memLat = 1;
    advanceTo(24'h000000, 1'b0); commit();
    check("postRstFetch", 64'(bufferOut), 64'({1'b1, 24'h000000, 32'hA0000000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
